// File: rtl/shift_accumulator.sv
// Shifted partial-product accumulator; optional result clamping via SHIFT_ACCUMULATOR_SATURATE_EN.
// One term per pp_valid&&pp_ready cycle, done one cycle after the last term; pp_valid gaps stall in ACCUM.
module shift_accumulator #(
  parameter int WIDTH     = 8,
  parameter int NUM_TERMS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pp_valid,
  input  logic [WIDTH-1:0]   pp_in,
  input  logic [1:0]         shift_cntrl,
  output logic               pp_ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               overflow
);

  localparam int AW = 2 * WIDTH;
  localparam logic [3:0] LAST_CNT = 4'(NUM_TERMS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   acc_q;
  logic [AW-1:0]   acc_d;
  logic [3:0]      cnt_q;
  logic            ovf_q;
  logic            ovf_d;
  logic [AW-1:0]   term_ext;
  logic [AW-1:0]   term;
  logic [AW:0]     sum;

  always_comb begin
    term_ext = {{WIDTH{1'b0}}, pp_in};
    term     = term_ext;
    case (shift_cntrl)
      2'b01:   term = term_ext << (WIDTH / 2);
      2'b10:   term = term_ext << WIDTH;
      default: term = term_ext;
    endcase
    sum   = {1'b0, acc_q} + {1'b0, term};
    ovf_d = ovf_q | sum[AW];
`ifdef SHIFT_ACCUMULATOR_SATURATE_EN
    // Once any carry has escaped, the result is pinned to all ones for the rest of the operation.
    acc_d = ovf_d ? {AW{1'b1}} : sum[AW-1:0];
`else
    acc_d = sum[AW-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= ACCUM;
          end else begin
            state_q <= IDLE;
          end
        end
        ACCUM: begin
          if (pp_valid) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == LAST_CNT) begin
              state_q <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pp_ready = (state_q == ACCUM);
  assign busy     = (state_q == ACCUM);
  assign done     = (state_q == DONE);
  assign result   = acc_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_shift_accumulator.sv
// Directed bench for shift_accumulator (WIDTH=8, NUM_TERMS=4); inputs change and outputs are sampled on negedge.
module tb_shift_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        pp_valid;
  logic [7:0]  pp_in;
  logic [1:0]  shift_cntrl;
  logic        pp_ready;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        overflow;

  int total;
  int bad;

`ifdef SHIFT_ACCUMULATOR_SATURATE_EN
  localparam logic [15:0] OVF_RESULT = 16'hFFFF;
  localparam logic [15:0] OVF_MID    = 16'hFFFF;
`else
  localparam logic [15:0] OVF_RESULT = 16'hFC00;
  localparam logic [15:0] OVF_MID    = 16'hFE00;
`endif

  shift_accumulator #(.WIDTH(8), .NUM_TERMS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pp_valid(pp_valid),
    .pp_in(pp_in), .shift_cntrl(shift_cntrl), .pp_ready(pp_ready),
    .busy(busy), .done(done), .result(result), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_term(input logic [7:0] pp, input logic [1:0] sh);
    int guard;
    guard = 0;
    pp_valid = 1'b1;
    pp_in = pp;
    shift_cntrl = sh;
    while (pp_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (guard >= 20) begin
      bad++;
      $display("FAIL send_term_timeout pp_ready=%b required=1", pp_ready);
    end
    @(negedge clk);
    pp_valid = 1'b0;
    pp_in = 8'h00;
    shift_cntrl = 2'b00;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (pp_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", pp_ready); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL rst_result got=%h exp=0000", result); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_mult();
    pulse_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mult_busy got=%b exp=1", busy); end
    total++; if (pp_ready !== 1'b1) begin bad++; $display("FAIL mult_ready got=%b exp=1", pp_ready); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL mult_clear got=%h exp=0000", result); end
    send_term(8'h8F, 2'b00);
    send_term(8'h82, 2'b01);
    send_term(8'h84, 2'b01);
    send_term(8'h78, 2'b10);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL mult_done got=%b exp=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mult_busy_done got=%b exp=0", busy); end
    total++; if (pp_ready !== 1'b0) begin bad++; $display("FAIL mult_ready_done got=%b exp=0", pp_ready); end
    total++; if (result !== 16'h88EF) begin bad++; $display("FAIL mult_result got=%h exp=88ef", result); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mult_ovf got=%b exp=0", overflow); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
    total++; if (result !== 16'h88EF) begin bad++; $display("FAIL mult_hold got=%h exp=88ef", result); end
  endtask

  task automatic test_overflow();
    pulse_start();
    send_term(8'hFF, 2'b10);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_first got=%b exp=0", overflow); end
    total++; if (result !== 16'hFF00) begin bad++; $display("FAIL ovf_first_res got=%h exp=ff00", result); end
    send_term(8'hFF, 2'b10);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_second got=%b exp=1", overflow); end
    total++; if (result !== OVF_MID) begin bad++; $display("FAIL ovf_mid_res got=%h exp=%h", result, OVF_MID); end
    send_term(8'hFF, 2'b10);
    send_term(8'hFF, 2'b10);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL ovf_done got=%b exp=1", done); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    total++; if (result !== OVF_RESULT) begin bad++; $display("FAIL ovf_result got=%h exp=%h", result, OVF_RESULT); end
    @(negedge clk);
  endtask

  task automatic test_shift11();
    pulse_start();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL s11_ovf_clear got=%b exp=0", overflow); end
    send_term(8'hAA, 2'b11);
    send_term(8'h00, 2'b00);
    send_term(8'h00, 2'b00);
    send_term(8'h00, 2'b00);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL s11_done got=%b exp=1", done); end
    total++; if (result !== 16'h00AA) begin bad++; $display("FAIL s11_result got=%h exp=00aa", result); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_term(8'h8F, 2'b00);
    send_term(8'h82, 2'b01);
    total++; if (result !== 16'h08AF) begin bad++; $display("FAIL rmid_partial got=%h exp=08af", result); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL rmid_result got=%h exp=0000", result); end
    total++; if (pp_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready got=%b exp=0", pp_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    pp_valid = 1'b1;
    pp_in = 8'h8F;
    shift_cntrl = 2'b00;
    repeat (3) @(negedge clk);
    pp_valid = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_nostart_busy got=%b exp=0", busy); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL rmid_nostart_res got=%h exp=0000", result); end
    pulse_start();
    send_term(8'h8F, 2'b00);
    send_term(8'h82, 2'b01);
    send_term(8'h84, 2'b01);
    send_term(8'h78, 2'b10);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL rmid_done got=%b exp=1", done); end
    total++; if (result !== 16'h88EF) begin bad++; $display("FAIL rmid_result2 got=%h exp=88ef", result); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  t_pp   [4];
    logic [1:0]  t_sh   [4];
    logic [15:0] t_part [4];
    logic [7:0]  s_pp   [4];
    logic [1:0]  s_sh   [4];
    t_pp = '{8'h8F, 8'h82, 8'h84, 8'h78};
    t_sh = '{2'b00, 2'b01, 2'b01, 2'b10};
    t_part = '{16'h008F, 16'h08AF, 16'h10EF, 16'h88EF};
    s_pp = '{8'hAA, 8'h00, 8'h00, 8'h00};
    s_sh = '{2'b11, 2'b00, 2'b00, 2'b00};

    pp_valid = 1'b1;
    pp_in = 8'h55;
    shift_cntrl = 2'b01;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pp_valid = 1'b0;
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL b2b_idle_junk got=%h exp=0000", result); end
    for (int i = 0; i < 4; i++) begin
      send_term(t_pp[i], t_sh[i]);
      total++; if (result !== t_part[i]) begin bad++; $display("FAIL b2b_partial%0d got=%h exp=%h", i, result, t_part[i]); end
      if (i < 3) begin
        repeat ($urandom_range(3, 0)) @(negedge clk);
        total++; if (busy !== 1'b1 || result !== t_part[i]) begin
          bad++; $display("FAIL b2b_stall%0d busy=%b res=%h exp busy=1 res=%h", i, busy, result, t_part[i]);
        end
      end
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done1 got=%b exp=1", done); end
    start = 1'b1;
    pp_valid = 1'b1;
    pp_in = 8'hFF;
    shift_cntrl = 2'b10;
    @(negedge clk);
    start = 1'b0;
    pp_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart_busy got=%b exp=1", busy); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL b2b_restart_res got=%h exp=0000", result); end
    for (int i = 0; i < 4; i++) begin
      send_term(s_pp[i], s_sh[i]);
      if (i < 3) repeat ($urandom_range(2, 0)) @(negedge clk);
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done2 got=%b exp=1", done); end
    total++; if (result !== 16'h00AA) begin bad++; $display("FAIL b2b_result2 got=%h exp=00aa", result); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || result !== 16'h00AA) begin
      bad++; $display("FAIL b2b_final busy=%b res=%h exp busy=0 res=00aa", busy, result);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    pp_valid = 1'b0;
    pp_in = 8'h00;
    shift_cntrl = 2'b00;
    test_reset();
    test_mult();
    test_overflow();
    test_shift11();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
